// File: rtl/div_seq.sv
// Sequential 32-bit restoring divider (DIV/DIVU) for the EX stage, {remainder, quotient} result.
// Latency: 34 edges from accept to ready_o (2 for divide-by-zero); the result holds until start_i drops.
// Backpressure: start_i stays high until EX consumes the result; annul_i cancels any in-flight divide.
module div_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   typedef enum logic [1:0] {
      DIV_FREE    = 2'd0,
      DIV_BY_ZERO = 2'd1,
      DIV_ON      = 2'd2,
      DIV_END     = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [64:0] work_q, work_d;
   logic [31:0] dvs_q, dvs_d;       // divisor magnitude
   logic        sign1_q, sign1_d;   // dividend sign bit
   logic        sign2_q, sign2_d;   // divisor sign bit
   logic        sgn_q, sgn_d;       // signed operation
   logic [63:0] result_q, result_d;
   logic        ready_q, ready_d;

   logic [31:0] abs1, abs2;
   logic [32:0] diff;
   logic [31:0] quot, rem;

   // Operand magnitudes, trial subtraction and sign-corrected final values
   always_comb begin
      abs1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
      abs2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
      diff = {1'b0, work_q[63:32]} - {1'b0, dvs_q};
      quot = (sgn_q && (sign1_q ^ sign2_q)) ? (~work_q[31:0] + 32'd1) : work_q[31:0];
      rem  = (sgn_q && sign1_q) ? (~work_q[64:33] + 32'd1) : work_q[64:33];
   end

   // Next-state and datapath updates for the divider sequencer
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      work_d   = work_q;
      dvs_d    = dvs_q;
      sign1_d  = sign1_q;
      sign2_d  = sign2_q;
      sgn_d    = sgn_q;
      result_d = result_q;
      ready_d  = ready_q;
      case (state_q)
         DIV_FREE: begin
            ready_d  = 1'b0;
            result_d = 64'd0;
            if (start_i && !annul_i) begin
               if (opdata2_i == 32'd0) begin
                  state_d = DIV_BY_ZERO;
               end else begin
                  state_d = DIV_ON;
                  cnt_d   = 6'd0;
                  work_d  = {32'd0, abs1, 1'b0};
               end
               dvs_d   = abs2;
               sign1_d = opdata1_i[31];
               sign2_d = opdata2_i[31];
               sgn_d   = signed_div_i;
            end
         end
         DIV_BY_ZERO: begin
            if (annul_i) begin
               state_d = DIV_FREE;
            end else begin
               state_d  = DIV_END;
               result_d = 64'd0;
               ready_d  = 1'b1;
            end
         end
         DIV_ON: begin
            if (annul_i) begin
               state_d = DIV_FREE;
               cnt_d   = 6'd0;
            end else if (cnt_q != 6'd32) begin
               // A negative trial difference means the divisor did not fit: shift in a 0
               if (diff[32]) begin
                  work_d = {work_q[63:0], 1'b0};
               end else begin
                  work_d = {diff[31:0], work_q[31:0], 1'b1};
               end
               cnt_d = cnt_q + 6'd1;
            end else begin
               result_d = {rem, quot};
               ready_d  = 1'b1;
               state_d  = DIV_END;
               cnt_d    = 6'd0;
            end
         end
         DIV_END: begin
            if (!start_i) begin
               state_d  = DIV_FREE;
               ready_d  = 1'b0;
               result_d = 64'd0;
            end
         end
         default: state_d = DIV_FREE;
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= DIV_FREE;
         cnt_q    <= 6'd0;
         work_q   <= 65'd0;
         dvs_q    <= 32'd0;
         sign1_q  <= 1'b0;
         sign2_q  <= 1'b0;
         sgn_q    <= 1'b0;
         result_q <= 64'd0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         work_q   <= work_d;
         dvs_q    <= dvs_d;
         sign1_q  <= sign1_d;
         sign2_q  <= sign2_d;
         sgn_q    <= sgn_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;

endmodule
